// File: rtl/ysyx_22040895_mdu.sv
// Iterative RV64M/RV32M multiply/divide unit for the execute stage.
// Radix-2 shift-add multiply, restoring divide; special cases finish at accept.
module ysyx_22040895_mdu #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [3:0]      mduop_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nxt;

    // Operation decode
    logic op_illegal, op_w, op_mul, op_hi, op_rem, sgn1, sgn2;
    always_comb begin
        op_illegal = 1'b0;
        op_w       = 1'b0;
        op_mul     = 1'b0;
        op_hi      = 1'b0;
        op_rem     = 1'b0;
        sgn1       = 1'b0;
        sgn2       = 1'b0;
        case (mduop_i)
            4'd0:  begin op_mul = 1'b1; sgn1 = 1'b1; sgn2 = 1'b1; end
            4'd1:  begin op_mul = 1'b1; op_hi = 1'b1; sgn1 = 1'b1; sgn2 = 1'b1; end
            4'd2:  begin op_mul = 1'b1; op_hi = 1'b1; sgn1 = 1'b1; end
            4'd3:  begin op_mul = 1'b1; op_hi = 1'b1; end
            4'd4:  begin sgn1 = 1'b1; sgn2 = 1'b1; end
            4'd5:  ;
            4'd6:  begin op_rem = 1'b1; sgn1 = 1'b1; sgn2 = 1'b1; end
            4'd7:  op_rem = 1'b1;
            4'd8:  begin op_w = 1'b1; op_mul = 1'b1; sgn1 = 1'b1; sgn2 = 1'b1; end
            4'd9:  begin op_w = 1'b1; sgn1 = 1'b1; sgn2 = 1'b1; end
            4'd10: op_w = 1'b1;
            4'd11: begin op_w = 1'b1; op_rem = 1'b1; sgn1 = 1'b1; sgn2 = 1'b1; end
            4'd12: begin op_w = 1'b1; op_rem = 1'b1; end
            default: op_illegal = 1'b1;
        endcase
        if (XLEN == 32 && op_w) begin
            op_illegal = 1'b1;
            op_w       = 1'b0;
        end
    end

    // Operand preparation: width/sign extension, then magnitudes
    logic [XLEN-1:0] ext1, ext2, mag1, mag2;
    logic            neg1, neg2;
    always_comb begin
        ext1 = op1_i;
        ext2 = op2_i;
        if (op_w) begin
            ext1 = sgn1 ? XLEN'($signed(op1_i[31:0])) : XLEN'(op1_i[31:0]);
            ext2 = sgn2 ? XLEN'($signed(op2_i[31:0])) : XLEN'(op2_i[31:0]);
        end
        neg1 = sgn1 & ext1[XLEN-1];
        neg2 = sgn2 & ext2[XLEN-1];
        mag1 = neg1 ? -ext1 : ext1;
        mag2 = neg2 ? -ext2 : ext2;
    end

    // Divide-by-zero and signed overflow, compared at the operation's width
    logic            div0, ovf, spec_hit;
    logic [XLEN-1:0] dvd_w, spec_val;
    always_comb begin
        dvd_w    = op_w ? XLEN'($signed(op1_i[31:0])) : op1_i;
        div0     = op_w ? (op2_i[31:0] == 32'd0) : (op2_i == '0);
        ovf      = sgn1 & (op_w ? (op1_i[31:0] == 32'h8000_0000 && op2_i[31:0] == 32'hFFFF_FFFF)
                                : (op1_i == MOST_NEG && op2_i == '1));
        spec_hit = 1'b0;
        spec_val = '0;
        if (!op_illegal && !op_mul) begin
            if (div0) begin
                spec_hit = 1'b1;
                spec_val = op_rem ? dvd_w : '1;
            end else if (ovf) begin
                spec_hit = 1'b1;
                spec_val = op_rem ? '0 : dvd_w;
            end
        end
    end

    logic            accept, last_iter;
    logic [CW-1:0]   cnt;
    logic            w_r, mul_r, hi_r, rem_r, negq_r, negr_r;

    assign accept    = (state == IDLE) && valid_i && !flush_i;
    assign last_iter = cnt == (w_r ? CW'(31) : CW'(XLEN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (spec_hit || op_illegal) ? DONE : CALC;
            CALC:    if (last_iter) state_nxt = DONE;
            DONE:    if (ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush_i) state_nxt = IDLE;
    end

    assign ready_o = (state == IDLE);
    assign valid_o = (state == DONE);
    assign busy_o  = (state == CALC) || (state == DONE);

    // Iteration datapath; the result is formed from post-iteration values so
    // the last iteration and the sign fix-up share the CALC->DONE edge.
    logic [2*XLEN-1:0] prod, mcand, prod_nxt, prod_s;
    logic [XLEN-1:0]   mplier, quo, rmd, dvsr;
    logic [XLEN-1:0]   quo_nxt, rmd_nxt, quo_s, rmd_s, raw, final_val, result_r;
    logic [XLEN:0]     shifted;
    logic              ge;
    always_comb begin
        prod_nxt = mplier[0] ? prod + mcand : prod;
        shifted  = {rmd, quo[XLEN-1]};
        ge       = shifted >= {1'b0, dvsr};
        rmd_nxt  = ge ? XLEN'(shifted - {1'b0, dvsr}) : shifted[XLEN-1:0];
        quo_nxt  = {quo[XLEN-2:0], ge};
        prod_s   = negq_r ? -prod_nxt : prod_nxt;
        quo_s    = negq_r ? -quo_nxt : quo_nxt;
        rmd_s    = negr_r ? -rmd_nxt : rmd_nxt;
        if (mul_r) raw = hi_r ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
        else       raw = rem_r ? rmd_s : quo_s;
        final_val = w_r ? XLEN'($signed(raw[31:0])) : raw;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            w_r      <= 1'b0;
            mul_r    <= 1'b0;
            hi_r     <= 1'b0;
            rem_r    <= 1'b0;
            negq_r   <= 1'b0;
            negr_r   <= 1'b0;
            prod     <= '0;
            mcand    <= '0;
            mplier   <= '0;
            rmd      <= '0;
            quo      <= '0;
            dvsr     <= '0;
            result_r <= '0;
        end else if (accept) begin
            cnt    <= '0;
            w_r    <= op_w;
            mul_r  <= op_mul;
            hi_r   <= op_hi;
            rem_r  <= op_rem;
            negq_r <= neg1 ^ neg2;
            negr_r <= neg1;
            prod   <= '0;
            mcand  <= (2*XLEN)'(mag1);
            mplier <= mag2;
            rmd    <= '0;
            // W dividends are left-aligned so 32 iterations consume them fully
            quo    <= op_w ? (mag1 << (XLEN - 32)) : mag1;
            dvsr   <= mag2;
            if (op_illegal || spec_hit) result_r <= spec_val;
        end else if (state == CALC && !flush_i) begin
            cnt    <= cnt + CW'(1);
            prod   <= prod_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            rmd    <= rmd_nxt;
            quo    <= quo_nxt;
            if (last_iter) result_r <= final_val;
        end
    end

    assign result_o = result_r;

endmodule

// File: doc/ysyx_22040895_mdu.md
# ysyx_22040895_mdu

Parametrised iterative multiply/divide unit implementing the RV64M/RV32M operations (MUL/MULH/MULHSU/MULHU, DIV/DIVU/REM/REMU and the W variants). It sits beside the single-cycle ALU inside the execute stage. The execute stage routes M-extension instructions here and stalls on the valid/ready handshake until the result returns. Multiplication uses radix-2 shift-add and division uses restoring shift-subtract, one bit per cycle, with RISC-V special-case semantics resolved in one cycle.

## Interface

Parameters:
- XLEN, 64, datapath width; legal values 32 or 64. With 32, W-ops are illegal.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- valid_i  in  1  request valid.
- ready_o  out  1  unit can accept; high only in IDLE.
- mduop_i  in  4  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU, 8 MULW, 9 DIVW, 10 DIVUW, 11 REMW, 12 REMUW; 13-15 illegal.
- op1_i  in  XLEN  rs1 value (dividend / multiplicand).
- op2_i  in  XLEN  rs2 value (divisor / multiplier).
- flush_i  in  1  abort any operation in progress.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer accepts result.
- result_o  out  XLEN  result, held stable while valid_o=1.
- busy_o  out  1  high in CALC or DONE.

## Operation

- Requests and operands are sampled on the edge where valid_i && ready_o && !flush_i.
- FSM states: IDLE, CALC, DONE.
  - IDLE→CALC on accept for a normal operation.
  - IDLE→DONE on accept for a special case or an illegal op.
  - CALC→DONE when the iteration counter reaches N-1. N=XLEN for full-width ops; N=32 for W-ops.
  - DONE→IDLE on valid_o && ready_i.
  - Any state→IDLE on flush_i. Flush has priority over every other transition.
- W-ops prepare operands as follows: take the low 32 bits of each operand, sign-extend (signed ops) or zero-extend (DIVUW/REMUW), iterate over 32 bits, then sign-extend result bit 31 to XLEN. This sign-extension applies to all W-ops, DIVUW/REMUW included.
- Signed ops compute on magnitudes. The sign is fixed on the CALC→DONE edge.
  - Product is negated when the operand signs differ.
  - Quotient is negated when the signs differ.
  - Remainder takes the dividend's sign.
  - MULHSU treats op1 as signed and op2 as unsigned.
- Products are 2*XLEN bits wide. MUL/MULW return the low half (low 32 bits for MULW); MULH* return the high half.
- Special cases, resolved at accept with no iteration:
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (most-negative / -1): quotient = dividend; remainder = 0.
  - Both cases use width-correct comparisons for W-ops.
- Illegal mduop_i codes are accepted and return result 0.
- result_o is a register. It is written only on entry to DONE and keeps its last value otherwise.

## Timing

- Reset (asynchronous assert) drives:
  - state=IDLE, so ready_o=1.
  - valid_o=0, busy_o=0, result_o=0, counter=0.
  - Reset mid-CALC abandons the operation immediately. No valid_o pulse is produced.
- Latency from the accept edge E0:
  - Normal ops: valid_o rises after edge E0+N+1. That is 65 edges for 64-bit ops and 33 edges for W-ops.
  - Special and illegal ops: valid_o rises after edge E0+1.
- Output handshake:
  - valid_o stays high, with result_o unchanged, until ready_i=1.
  - ready_i may already be high in the first DONE cycle; the unit then returns to IDLE on the next edge.
- Back-to-back operation is not supported. ready_o is low from accept until the edge after the output handshake, so the earliest next accept is the cycle after DONE exits.
- Flush:
  - flush_i in CALC or DONE sends the FSM to IDLE on the next edge. valid_o is 0 from that edge on.
  - flush_i together with valid_i in IDLE: the request is not accepted.
- ready_o, valid_o and busy_o are decoded from state only. They are independent of the *_i inputs in the same cycle.

## Test plan

- MUL op1=7, op2=0xFFFF_FFFF_FFFF_FFFD → result 0xFFFF_FFFF_FFFF_FFEB, valid_o rises exactly 65 edges after accept, busy_o high throughout.
- MULHU op1=op2=0xFFFF_FFFF_FFFF_FFFF → result 0xFFFF_FFFF_FFFF_FFFE. MULH op1=-1, op2=-1 → result 0.
- DIV -7/2 → 0xFFFF_FFFF_FFFF_FFFD. REM -7/2 → 0xFFFF_FFFF_FFFF_FFFF. DIVUW op1=0x1_0000_0010, op2=0x2 → 0x8 in 33 edges.
- Special cases, each with valid_o one edge after accept:
  - DIVU x/0 → all ones.
  - REM 0x8000_0000_0000_0000 / -1 → 0.
  - DIVW op1=0x8000_0000, op2=0xFFFF_FFFF → 0xFFFF_FFFF_8000_0000.
- Hold ready_i=0 for 10 cycles in DONE → valid_o and result_o stay constant and ready_o stays low. Raise ready_i → IDLE next edge, ready_o=1.
- Assert flush_i on CALC cycle 20 → IDLE next edge, and valid_o never asserts. Repeat with rst pulsed asynchronously mid-CALC → all outputs reach reset values immediately. A new MUL 3*5 afterwards → 15.
